// File: rtl/i8080_pkg.sv
// Shared 8080 opcode constants and the opcode-to-length decode, used by the
// fetch aligner and the CPU decoder.
package i8080_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_SHLD  = 8'h22;
  localparam logic [7:0] OP_LHLD  = 8'h2A;
  localparam logic [7:0] OP_STA   = 8'h32;
  localparam logic [7:0] OP_LDA   = 8'h3A;
  localparam logic [7:0] OP_JMP   = 8'hC3;
  localparam logic [7:0] OP_CALL  = 8'hCD;
  localparam logic [7:0] OP_OUT   = 8'hD3;
  localparam logic [7:0] OP_IN    = 8'hDB;

  typedef logic [1:0] ins_len_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] imm;
    ins_len_t    len;
    logic [15:0] pc;
  } fetch_ins_t;

  // Patterns: LXI 00rp0001, Jccc 11ccc010, Cccc 11ccc100, MVI 00rrr110,
  // ALU-immediate 11aaa110.
  function automatic ins_len_t opLen(input logic [7:0] op);
    ins_len_t len;
    len = 2'd1;
    casez (op)
      8'b00??_0001, OP_SHLD, OP_LHLD, OP_STA, OP_LDA, OP_JMP, OP_CALL,
      8'b11??_?010, 8'b11??_?100:
        len = 2'd3;
      8'b00??_?110, 8'b11??_?110, OP_IN, OP_OUT:
        len = 2'd2;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue: pushes 0..2 bytes and pops 0..3 bytes per cycle,
// exposes the three head bytes and the occupancy.
module byte_fifo
  import i8080_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [1:0]    push_cnt_i,
  input  logic [15:0]   push_data_i,
  input  ins_len_t      pop_cnt_i,
  output logic [23:0]   peek_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q + AW'(pop_cnt_i);
    wr_d  = wr_q + AW'(push_cnt_i);
    cnt_d = cnt_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_cnt_i);
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: bytes beyond the occupancy are never presented.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (push_cnt_i != 2'd0) mem_q[wr_q] <= push_data_i[7:0];
      if (push_cnt_i == 2'd2) mem_q[wr_q + AW'(1)] <= push_data_i[15:8];
    end
  end

  assign peek_o  = {mem_q[rd_q + AW'(2)], mem_q[rd_q + AW'(1)], mem_q[rd_q]};
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_align.sv
// 8080 fetch aligner: fetches 16-bit words into a byte queue and presents
// whole variable-length instructions (1..3 bytes) to the decoder.
module fetch_align
  import i8080_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [14:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_opcode,
  output logic [15:0] ins_imm,
  output logic [1:0]  ins_len,
  output logic [15:0] ins_pc
);

  localparam int AW = $clog2(QDEPTH);

  logic [15:0] fpc_q, fpc_d;
  logic [15:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic        odd_q, odd_d;

  logic [1:0]  push_cnt;
  logic [15:0] push_data;
  ins_len_t    pop_cnt;
  logic [23:0] peek;
  logic [AW:0] occ;
  logic [AW+1:0] reserved;
  logic        handshake;
  fetch_ins_t  head;

  byte_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_cnt_i (push_cnt),
    .push_data_i(push_data),
    .pop_cnt_i  (pop_cnt),
    .peek_o     (peek),
    .count_o    (occ)
  );

  // Head instruction view; bytes not yet queued read as zero so the outputs
  // sit at 0/0/1/pc whenever the queue is empty, including reset.
  always_comb begin
    head.opcode = (occ != '0) ? peek[7:0] : 8'h00;
    head.len    = opLen(head.opcode);
    head.imm    = 16'h0000;
    if (head.len != 2'd1 && occ >= (AW+1)'(2)) head.imm[7:0]  = peek[15:8];
    if (head.len == 2'd3 && occ >= (AW+1)'(3)) head.imm[15:8] = peek[23:16];
    head.pc     = pc_q;
  end

  assign ins_valid  = (occ >= (AW+1)'(head.len));
  assign ins_opcode = head.opcode;
  assign ins_imm    = head.imm;
  assign ins_len    = head.len;
  assign ins_pc     = head.pc;
  assign handshake  = ins_valid && ins_ready;

  // A request reserves two slots, and an outstanding word holds two more.
  always_comb begin
    reserved  = {1'b0, occ} + {{AW{1'b0}}, inflight_q, 1'b0};
    mem_req   = rst_n && !redirect && (reserved <= (AW+2)'(QDEPTH - 2));
    mem_raddr = fpc_q[15:1];
  end

  always_comb begin
    push_cnt  = 2'd0;
    push_data = mem_rdata;
    if (inflight_q && !redirect) begin
      if (odd_q) begin
        push_cnt  = 2'd1;
        push_data = {8'h00, mem_rdata[15:8]};
      end else begin
        push_cnt  = 2'd2;
      end
    end
    pop_cnt    = handshake ? head.len : 2'd0;
    inflight_d = mem_req;
    odd_d      = mem_req ? fpc_q[0] : odd_q;

    fpc_d = fpc_q;
    pc_d  = pc_q;
    if (redirect) begin
      fpc_d = redirect_pc;
      pc_d  = redirect_pc;
    end else begin
      if (mem_req)   fpc_d = {fpc_q[15:1] + 15'd1, 1'b0};
      if (handshake) pc_d  = pc_q + {14'd0, head.len};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= 16'h0000;
      pc_q       <= 16'h0000;
      inflight_q <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      odd_q      <= odd_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: a byte-array memory model feeds the DUT
// and a queue of expected instructions is compared on every handshake.
module tb_fetch_align;

  localparam int QDEPTH = 8;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } expIns_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_opcode;
  logic [15:0] ins_imm;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;

  logic [7:0] memBytes [65536];
  logic [1:0] lenTab [256];
  expIns_t    sbQ [$];
  int         vecCount = 0;
  int         errCount = 0;
  int         hsCount  = 0;

  logic [7:0] threeOps [26] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
                                8'hC3, 8'hCD, 8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA,
                                8'hF2, 8'hFA, 8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC,
                                8'hF4, 8'hFC};
  logic [7:0] twoOps [18]   = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                                8'hDB, 8'hD3};
  logic [7:0] mixProg [26]  = '{8'h3E, 8'h5A, 8'h21, 8'h34, 8'h12, 8'h00, 8'hC6, 8'h07,
                                8'hCD, 8'h00, 8'h10, 8'hDB, 8'h10, 8'h3A, 8'h55, 8'hAA,
                                8'h76, 8'hFE, 8'h01, 8'hC2, 8'h00, 8'h02, 8'hD3, 8'h20,
                                8'h06, 8'h99};

  fetch_align #(.QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_opcode (ins_opcode),
    .ins_imm    (ins_imm),
    .ins_len    (ins_len),
    .ins_pc     (ins_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) mem_rdata <= {memBytes[{mem_raddr, 1'b1}], memBytes[{mem_raddr, 1'b0}]};
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    ins_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic buildExpected(input logic [15:0] startPc, input int n);
    logic [15:0] p;
    expIns_t e;
    p = startPc;
    sbQ.delete();
    for (int i = 0; i < n; i++) begin
      e.op  = memBytes[p];
      e.len = lenTab[e.op];
      e.imm = 16'h0000;
      if (e.len >= 2'd2) e.imm[7:0]  = memBytes[p + 16'd1];
      if (e.len == 2'd3) e.imm[15:8] = memBytes[p + 16'd2];
      e.pc  = p;
      sbQ.push_back(e);
      p = p + 16'(e.len);
    end
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (ins_valid) seen = 1'b1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    expIns_t e;
    if (rst_n && ins_valid && ins_ready) begin
      hsCount++;
      if (sbQ.size() == 0) begin
        checkOutput("sb_underflow", 64'(ins_pc), 64'hFFFF_FFFF);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_ins", {ins_opcode, ins_imm, ins_len, ins_pc}, {e.op, e.imm, e.len, e.pc});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    int hsStart;

    for (int i = 0; i < 256; i++) lenTab[i] = 2'd1;
    foreach (threeOps[i]) lenTab[threeOps[i]] = 2'd3;
    foreach (twoOps[i]) lenTab[twoOps[i]] = 2'd2;
    for (int i = 0; i < 65536; i++) memBytes[i] = 8'h00;
    foreach (mixProg[i]) memBytes[16'h0200 + i] = mixProg[i];
    memBytes[16'h0100] = 8'hC3;
    memBytes[16'h0101] = 8'h06;
    memBytes[16'h0102] = 8'h77;
    memBytes[16'h0103] = 8'h01;
    memBytes[16'h0104] = 8'hEF;
    memBytes[16'h0105] = 8'hBE;
    memBytes[16'hFFFF] = 8'h21;

    rst_n       = 1'b0;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    // Reset, then a stream of NOPs from address 0.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outs", {mem_req, ins_valid, ins_opcode, ins_imm, ins_len, ins_pc},
                {1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000});
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ins_ready = 1'b1;
    buildExpected(16'h0000, 200);
    @(negedge clk);
    checkOutput("c0_req", {mem_req, mem_raddr}, {1'b1, 15'h0000});
    checkOutput("c0_valid", 64'(ins_valid), 64'd0);
    @(negedge clk);
    checkOutput("c1_valid", 64'(ins_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("nop_stream", {ins_valid, ins_pc}, {1'b1, 16'(i)});
    end

    // JMP 0x1234 at odd byte 0x0003, split across two words.
    applyStimulus(1'b1, 1'b1, 16'h0003);
    memBytes[16'h0003] = 8'hC3;
    memBytes[16'h0004] = 8'h34;
    memBytes[16'h0005] = 8'h12;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    buildExpected(16'h0003, 200);
    waitValid("jmp_wait", 10);
    checkOutput("jmp", {ins_opcode, ins_imm, ins_len, ins_pc}, {8'hC3, 16'h1234, 2'd3, 16'h0003});
    repeat (10) @(negedge clk);

    // MVI A,0x5A at the head while the decoder stalls for 20 cycles.
    applyStimulus(1'b0, 1'b1, 16'h0200);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    buildExpected(16'h0200, 200);
    waitValid("mvi_wait", 10);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall_hold", {ins_valid, ins_opcode, ins_imm, ins_len, ins_pc},
                  {1'b1, 8'h3E, 16'h005A, 2'd2, 16'h0200});
      if (i >= 15) checkOutput("stall_nofetch", 64'(mem_req), 64'd0);
    end
    hsStart = hsCount;
    for (int i = 0; i < 120; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("drain_progress", 64'((hsCount - hsStart) >= 30), 64'd1);

    // Redirect to 0x0101 while a word is outstanding.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req) found = 1'b1;
    end
    checkOutput("inflight_wait", 64'(found), 64'd1);
    applyStimulus(1'b1, 1'b1, 16'h0101);
    @(negedge clk);
    checkOutput("redir_noreq", 64'(mem_req), 64'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    buildExpected(16'h0101, 200);
    @(negedge clk);
    checkOutput("redir_req", {mem_req, mem_raddr}, {1'b1, 15'h0080});
    checkOutput("redir_empty", 64'(ins_valid), 64'd0);
    waitValid("redir_wait", 10);
    checkOutput("redir_first", {ins_opcode, ins_imm, ins_len, ins_pc}, {8'h06, 16'h0077, 2'd2, 16'h0101});
    repeat (10) @(negedge clk);

    // LXI at 0xFFFF takes its operands from 0x0000/0x0001; both PCs wrap.
    applyStimulus(1'b1, 1'b1, 16'hFFFD);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    buildExpected(16'hFFFD, 200);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ins_valid && ins_pc == 16'h0002) found = 1'b1;
    end
    checkOutput("wrap_pc", 64'(found), 64'd1);

    // Reset pulsed mid-stream, then restart from address 0.
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outs", {mem_req, ins_valid, ins_opcode, ins_imm, ins_len, ins_pc},
                {1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    buildExpected(16'h0000, 200);
    @(negedge clk);
    checkOutput("rst_c0_req", {mem_req, mem_raddr}, {1'b1, 15'h0000});
    @(negedge clk);
    checkOutput("rst_c1_valid", 64'(ins_valid), 64'd0);
    @(negedge clk);
    checkOutput("rst_c2_first", {ins_valid, ins_pc}, {1'b1, 16'h0000});
    hsStart = hsCount;
    repeat (20) @(negedge clk);
    checkOutput("rst_progress", 64'((hsCount - hsStart) >= 10), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
